// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller.
//   - 3-bit state encoding (FETCH..HALT)
//   - 4-bit opcode constants and a legality check
//   - select values for the datapath's 2:1 muxes
//   - ctrl_t: bundle of the controller's strobes/selects
package multicycle_ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic SEL_REG = 1'b0;  // operand B: rt register
  localparam logic SEL_IMM = 1'b1;  // operand B: sign-extended immediate
  localparam logic SEL_ALU = 1'b0;  // writeback: ALU result
  localparam logic SEL_MEM = 1'b1;  // writeback: memory data
  localparam logic SEL_PC1 = 1'b0;  // next PC: PC+1
  localparam logic SEL_TGT = 1'b1;  // next PC: branch/jump target

  typedef struct packed {
    logic ir_load;
    logic pc_load;
    logic pc_sel;
    logic alu_b_sel;
    logic wb_sel;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic halted;
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW,
      OP_BEQ, OP_JMP, OP_HALT: is_legal = 1'b1;
      default:                 is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   master: the controller (takes opcode/zero/mem_ready, drives strobes/selects/status)
//   slave : the datapath side
interface multicycle_ctrl_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_load;
  logic       pc_load;
  logic       pc_sel;
  logic       alu_b_sel;
  logic       wb_sel;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       halted;
  logic       fault;

  modport master (
    input  opcode, zero, mem_ready,
    output ir_load, pc_load, pc_sel, alu_b_sel, wb_sel,
           reg_write, mem_read, mem_write, halted, fault
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ir_load, pc_load, pc_sel, alu_b_sel, wb_sel,
           reg_write, mem_read, mem_write, halted, fault
  );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// mc_wait_timer: stall counter for memory accesses.
//   clk, clear : clock / synchronous active-high reset
//   stall      : controller is in FETCH or MEM without mem_ready
//   timeout    : this stalled cycle is the TIMEOUT-th one
// The count returns to zero on any non-stalled cycle (i.e. state exit)
// and on the timeout edge, which also leaves the state.
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic stall,
  output logic timeout
);
  logic [7:0] cnt_q;

  assign timeout = stall && (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (clear || !stall || timeout) cnt_q <= 8'd0;
    else                            cnt_q <= cnt_q + 8'd1;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the term-project
// datapath. Drives the 2:1 mux selects, PC/IR/register/memory enables.
//   clk, clear : clock / synchronous active-high reset (forces outputs to 0)
//   bus        : multicycle_ctrl_if.master (opcode, zero, mem_ready in;
//                strobes, selects, halted, fault out)
// Optional: MULTICYCLE_CTRL_MEM_WAIT_EN makes FETCH/MEM wait on mem_ready
// with a TIMEOUT-cycle fault; otherwise every access completes in one cycle.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               clear,
  multicycle_ctrl_if.master  bus
);
  logic [2:0] state_q, state_d;
  logic [3:0] op_q;
  logic       fault_q, fault_set;
  logic       done, tmo;
  ctrl_t      c;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  logic stall;
  assign stall = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;
  assign done  = bus.mem_ready;  // ready beats a coincident timeout
  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk     (clk),
    .clear   (clear),
    .stall   (stall),
    .timeout (tmo)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{bus.mem_ready, 8'(TIMEOUT)};
  assign done      = 1'b1;
  assign tmo       = 1'b0;
`endif

  // Next state. DECODE looks at the live opcode; later states use op_q.
  always_comb begin
    state_d   = state_q;
    fault_set = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (done)     state_d = ST_DECODE;
        else if (tmo) begin state_d = ST_HALT; fault_set = 1'b1; end
      end
      ST_DECODE: begin
        if (bus.opcode == OP_HALT)   state_d = ST_HALT;
        else if (!is_legal(bus.opcode)) begin state_d = ST_HALT; fault_set = 1'b1; end
        else                         state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB, OP_ADDI: state_d = ST_WB;
          OP_LW, OP_SW:            state_d = ST_MEM;
          default:                 state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (done)     state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
        else if (tmo) begin state_d = ST_HALT; fault_set = 1'b1; end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_FETCH;
      op_q    <= 4'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= bus.opcode;
      if (fault_set)            fault_q <= 1'b1;
    end
  end

  // Output decode. clear dominates so nothing fires (or goes X) during reset.
  always_comb begin
    c = '0;
    if (!clear) begin
      case (state_q)
        ST_FETCH: begin
          c.mem_read = 1'b1;
          c.ir_load  = done;
          c.pc_load  = done;
          c.pc_sel   = SEL_PC1;
        end
        ST_EXEC: begin
          case (op_q)
            OP_ADDI, OP_LW, OP_SW: c.alu_b_sel = SEL_IMM;
            OP_BEQ: begin
              c.alu_b_sel = SEL_REG;
              c.pc_sel    = SEL_TGT;
              c.pc_load   = bus.zero;
            end
            OP_JMP: begin
              c.pc_sel  = SEL_TGT;
              c.pc_load = 1'b1;
            end
            default: c.alu_b_sel = SEL_REG;
          endcase
        end
        ST_MEM: begin
          c.mem_read  = (op_q == OP_LW);
          c.mem_write = (op_q == OP_SW);
        end
        ST_WB: begin
          c.reg_write = 1'b1;
          c.wb_sel    = (op_q == OP_LW) ? SEL_MEM : SEL_ALU;
        end
        ST_HALT: c.halted = 1'b1;
        default: c = '0;
      endcase
    end
  end

  assign bus.ir_load   = c.ir_load;
  assign bus.pc_load   = c.pc_load;
  assign bus.pc_sel    = c.pc_sel;
  assign bus.alu_b_sel = c.alu_b_sel;
  assign bus.wb_sel    = c.wb_sel;
  assign bus.reg_write = c.reg_write;
  assign bus.mem_read  = c.mem_read;
  assign bus.mem_write = c.mem_write;
  assign bus.halted    = c.halted;
  assign bus.fault     = fault_q && !clear;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.TIMEOUT(3)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // Expected output vector:
  // {ir_load,pc_load,pc_sel,alu_b_sel,wb_sel,reg_write,mem_read,mem_write,halted,fault}
  localparam logic [9:0] E_FETCH  = 10'b1100001000;
  localparam logic [9:0] E_FSTALL = 10'b0000001000;
  localparam logic [9:0] E_ZERO   = 10'b0000000000;
  localparam logic [9:0] E_IMM    = 10'b0001000000;
  localparam logic [9:0] E_BR_T   = 10'b0110000000;
  localparam logic [9:0] E_BR_N   = 10'b0010000000;
  localparam logic [9:0] E_MRD    = 10'b0000001000;
  localparam logic [9:0] E_MWR    = 10'b0000000100;
  localparam logic [9:0] E_WB_ALU = 10'b0000010000;
  localparam logic [9:0] E_WB_MEM = 10'b0000110000;
  localparam logic [9:0] E_HALT   = 10'b0000000010;
  localparam logic [9:0] E_HALTF  = 10'b0000000011;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       clr;
    logic       rdy;
    logic [9:0] exp;
    string      nm;
  } step_t;

  step_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic push(input logic [3:0] op, input logic z, input logic clr,
                      input logic rdy, input logic [9:0] exp, input string nm);
    step_t s;
    s.op = op; s.z = z; s.clr = clr; s.rdy = rdy; s.exp = exp; s.nm = nm;
    sbq.push_back(s);
  endtask

  // Expected per-cycle outputs of one instruction with no memory waits.
  task automatic plan_instr(input logic [3:0] op, input logic z, input string nm);
    push(op, z, 0, 1, E_FETCH, {nm, ".fetch"});
    push(op, z, 0, 1, E_ZERO,  {nm, ".decode"});
    case (op)
      4'b0000, 4'b0001: begin
        push(op, z, 0, 1, E_ZERO,   {nm, ".exec"});
        push(op, z, 0, 1, E_WB_ALU, {nm, ".wb"});
      end
      4'b0010: begin
        push(op, z, 0, 1, E_IMM,    {nm, ".exec"});
        push(op, z, 0, 1, E_WB_ALU, {nm, ".wb"});
      end
      4'b0100: begin
        push(op, z, 0, 1, E_IMM,    {nm, ".exec"});
        push(op, z, 0, 1, E_MRD,    {nm, ".mem"});
        push(op, z, 0, 1, E_WB_MEM, {nm, ".wb"});
      end
      4'b0101: begin
        push(op, z, 0, 1, E_IMM, {nm, ".exec"});
        push(op, z, 0, 1, E_MWR, {nm, ".mem"});
      end
      4'b1000: push(op, z, 0, 1, z ? E_BR_T : E_BR_N, {nm, ".exec"});
      4'b1100: push(op, z, 0, 1, E_BR_T, {nm, ".exec"});
      4'b1111: push(op, z, 0, 1, E_HALT, {nm, ".halt"});
      default: push(op, z, 0, 1, E_HALTF, {nm, ".halt"});
    endcase
  endtask

  // Pop the scoreboard: drive each step's inputs, then compare outputs.
  task automatic run_queue();
    step_t s;
    logic [9:0] got;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      @(negedge clk);
      bus.opcode = s.op; bus.zero = s.z; bus.mem_ready = s.rdy; clear = s.clr;
      #1;
      got = {bus.ir_load, bus.pc_load, bus.pc_sel, bus.alu_b_sel, bus.wb_sel,
             bus.reg_write, bus.mem_read, bus.mem_write, bus.halted, bus.fault};
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", s.nm, cyc, got, s.exp);
      end
      cyc++;
    end
  endtask

  task automatic do_clear(input string nm);
    push(4'b0000, 0, 1, 1, E_ZERO, {nm, ".clear"});
    run_queue();
  endtask

  task automatic test_reset();
    push(4'b0000, 0, 1, 1, E_ZERO, "reset.held");
    push(4'b0000, 0, 1, 0, E_ZERO, "reset.held2");
    plan_instr(4'b0000, 0, "reset.add");
    run_queue();
  endtask

  task automatic test_alu();
    plan_instr(4'b0000, 0, "add");
    plan_instr(4'b0001, 1, "sub");
    plan_instr(4'b0010, 0, "addi");
    run_queue();
  endtask

  task automatic test_load_store();
    plan_instr(4'b0100, 0, "lw");
    plan_instr(4'b0101, 0, "sw");
    run_queue();
  endtask

  task automatic test_branch();
    plan_instr(4'b1000, 1, "beq_t");
    plan_instr(4'b1000, 0, "beq_n");
    plan_instr(4'b1100, 0, "jmp");
    run_queue();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [7];
    ops = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0101, 4'b1100, 4'b0001};
    for (int r = 0; r < 3; r++)
      foreach (ops[i]) plan_instr(ops[i], 1'($urandom_range(0, 1)), $sformatf("b2b%0d_%0d", r, i));
    run_queue();
  endtask

  task automatic test_clear_mid();
    push(4'b0000, 0, 0, 1, E_FETCH, "clrmid.fetch");
    push(4'b0000, 0, 0, 1, E_ZERO,  "clrmid.decode");
    push(4'b0000, 0, 0, 1, E_ZERO,  "clrmid.exec");
    push(4'b0000, 0, 1, 1, E_ZERO,  "clrmid.wb_clear");
    plan_instr(4'b0010, 0, "clrmid.after");
    // clear in MEM of SW must also suppress mem_write
    push(4'b0101, 0, 0, 1, E_FETCH, "clrsw.fetch");
    push(4'b0101, 0, 0, 1, E_ZERO,  "clrsw.decode");
    push(4'b0101, 0, 0, 1, E_IMM,   "clrsw.exec");
    push(4'b0101, 0, 1, 1, E_ZERO,  "clrsw.mem_clear");
    plan_instr(4'b0000, 0, "clrsw.after");
    run_queue();
  endtask

  task automatic test_illegal();
    plan_instr(4'b0111, 0, "illegal");
    push(4'b0000, 0, 0, 1, E_HALTF, "illegal.stay1");
    push(4'b0000, 0, 0, 1, E_HALTF, "illegal.stay2");
    run_queue();
    do_clear("illegal");
    plan_instr(4'b0000, 0, "illegal.recover");
    plan_instr(4'b1111, 0, "haltop");
    push(4'b0000, 0, 0, 1, E_HALT, "haltop.stay");
    run_queue();
    do_clear("haltop");
    plan_instr(4'b0010, 0, "haltop.recover");
    run_queue();
  endtask

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  task automatic test_mem_wait();
    // SW never ready: three stalled cycles then HALT with fault
    push(4'b0101, 0, 0, 1, E_FETCH, "swto.fetch");
    push(4'b0101, 0, 0, 1, E_ZERO,  "swto.decode");
    push(4'b0101, 0, 0, 1, E_IMM,   "swto.exec");
    for (int k = 0; k < 3; k++) push(4'b0101, 0, 0, 0, E_MWR, $sformatf("swto.stall%0d", k));
    push(4'b0101, 0, 0, 0, E_HALTF, "swto.halt");
    run_queue();
    do_clear("swto");
    // SW ready on 2nd stalled cycle
    push(4'b0101, 0, 0, 1, E_FETCH, "swrdy.fetch");
    push(4'b0101, 0, 0, 1, E_ZERO,  "swrdy.decode");
    push(4'b0101, 0, 0, 1, E_IMM,   "swrdy.exec");
    push(4'b0101, 0, 0, 0, E_MWR,   "swrdy.stall");
    push(4'b0101, 0, 0, 1, E_MWR,   "swrdy.done");
    // FETCH stall, then LW whose ready coincides with the timeout cycle
    push(4'b0100, 0, 0, 0, E_FSTALL, "lw.fstall");
    push(4'b0100, 0, 0, 1, E_FETCH,  "lw.fetch");
    push(4'b0100, 0, 0, 1, E_ZERO,   "lw.decode");
    push(4'b0100, 0, 0, 1, E_IMM,    "lw.exec");
    push(4'b0100, 0, 0, 0, E_MRD,    "lw.stall0");
    push(4'b0100, 0, 0, 0, E_MRD,    "lw.stall1");
    push(4'b0100, 0, 0, 1, E_MRD,    "lw.rdy_at_to");
    push(4'b0100, 0, 0, 1, E_WB_MEM, "lw.wb");
    plan_instr(4'b0000, 0, "wait.after");
    run_queue();
  endtask
`else
  task automatic test_mem_wait();
    // mem_ready is ignored: accesses complete in one cycle regardless
    push(4'b0100, 0, 0, 0, E_FETCH,  "nordy.fetch");
    push(4'b0100, 0, 0, 0, E_ZERO,   "nordy.decode");
    push(4'b0100, 0, 0, 0, E_IMM,    "nordy.exec");
    push(4'b0100, 0, 0, 0, E_MRD,    "nordy.mem");
    push(4'b0100, 0, 0, 0, E_WB_MEM, "nordy.wb");
    push(4'b0101, 0, 0, 0, E_FETCH,  "nordy.sw_fetch");
    push(4'b0101, 0, 0, 0, E_ZERO,   "nordy.sw_decode");
    push(4'b0101, 0, 0, 0, E_IMM,    "nordy.sw_exec");
    push(4'b0101, 0, 0, 0, E_MWR,    "nordy.sw_mem");
    push(4'b0000, 0, 0, 0, E_FETCH,  "nordy.next_fetch");
    run_queue();
    do_clear("nordy");
  endtask
`endif

  initial begin
    clear = 1'b1;
    bus.opcode = 4'b0000; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_clear_mid();
    test_mem_wait();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
